vram_port_arbiter: RTL and testbench

- Shares the single 8-bit CPU-side VRAM port (14-bit address, synchronous 1-cycle read) between two requesters: the Z80 bus interface (CPU) and the VRAM copy/fill engine (DMA).
- CPU has fixed priority; a starvation guard bounds DMA wait.
- Each requester has a req/ack handshake and a registered read-data return with a valid strobe.
- Sits between the bus/DMA logic and the VRAM CPU port, in the VRAM port-1 clock domain.

---
 rtl/vram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// CPU-priority arbiter for VRAM port 1 with a DMA starvation guard: grant/ack 1 cycle after req, read data 3 cycles after req.
// Requesters hold req until ack (no queueing); define VRAM_ARB_STATS_EN to add the DMA stall counter and its clear input.
module vram_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [13:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_wrdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rddata,
  output logic        cpu_rdvalid,
  input  logic        dma_req,
  input  logic [13:0] dma_addr,
  input  logic        dma_wren,
  input  logic [7:0]  dma_wrdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rddata,
  output logic        dma_rdvalid,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wrdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_rddata
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] dma_stall_cnt
`endif
);

  typedef struct packed {
    logic [13:0] addr;
    logic        wren;
    logic [7:0]  wrdata;
  } req_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  req_t       cpu_bus;
  req_t       dma_bus;
  req_t       win_bus;
  logic       cpu_elig;
  logic       dma_elig;
  logic       dma_force;
  logic       grant_cpu;
  logic       grant_dma;
  logic       grant_any;
  logic [3:0] wait_cnt;

  // Two-stage read tag pipeline: stage 1 aligns with the address on the
  // port, stage 2 with the data coming back from the RAM.
  logic       s1_vld;
  owner_t     s1_own;
  logic       s2_vld;
  owner_t     s2_own;

  always_comb begin
    cpu_bus.addr   = cpu_addr;
    cpu_bus.wren   = cpu_wren;
    cpu_bus.wrdata = cpu_wrdata;
    dma_bus.addr   = dma_addr;
    dma_bus.wren   = dma_wren;
    dma_bus.wrdata = dma_wrdata;
  end

  // A requester sitting in its ack cycle is ineligible, which is what lets
  // a continuously-requesting CPU still leave every other slot to DMA.
  always_comb begin
    cpu_elig  = cpu_req & ~cpu_ack;
    dma_elig  = dma_req & ~dma_ack;
    dma_force = dma_elig && (wait_cnt == WAIT_LIM);
    grant_dma = dma_elig && (dma_force || !cpu_elig);
    grant_cpu = cpu_elig && !grant_dma;
    grant_any = grant_cpu || grant_dma;
    win_bus   = grant_dma ? dma_bus : cpu_bus;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_addr   <= '0;
      vram_wrdata <= '0;
      vram_wren   <= 1'b0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
    end else begin
      cpu_ack   <= grant_cpu;
      dma_ack   <= grant_dma;
      vram_wren <= grant_any && win_bus.wren;
      if (grant_any) begin
        vram_addr   <= win_bus.addr;
        vram_wrdata <= win_bus.wrdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_own <= OWN_CPU;
      s2_vld <= 1'b0;
      s2_own <= OWN_CPU;
    end else begin
      s1_vld <= grant_any && !win_bus.wren;
      s1_own <= grant_dma ? OWN_DMA : OWN_CPU;
      s2_vld <= s1_vld;
      s2_own <= s1_own;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rddata  <= '0;
      cpu_rdvalid <= 1'b0;
      dma_rddata  <= '0;
      dma_rdvalid <= 1'b0;
    end else begin
      cpu_rdvalid <= s2_vld && (s2_own == OWN_CPU);
      dma_rdvalid <= s2_vld && (s2_own == OWN_DMA);
      if (s2_vld && (s2_own == OWN_CPU)) cpu_rddata <= vram_rddata;
      if (s2_vld && (s2_own == OWN_DMA)) dma_rddata <= vram_rddata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (grant_dma) begin
      wait_cnt <= '0;
    end else if (dma_elig && (wait_cnt != WAIT_LIM)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_stall_cnt <= '0;
    end else if (stats_clr) begin
      dma_stall_cnt <= '0;
    end else if (dma_elig && !grant_dma && (dma_stall_cnt != 16'hFFFF)) begin
      dma_stall_cnt <= dma_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural 16K x 8 VRAM (1-cycle synchronous read).
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_wren, cpu_ack, cpu_rdvalid;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wrdata, cpu_rddata;
  logic        dma_req, dma_wren, dma_ack, dma_rdvalid;
  logic [13:0] dma_addr;
  logic [7:0]  dma_wrdata, dma_rddata;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wrdata, vram_rddata;
  logic        vram_wren;
`ifdef VRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] dma_stall_cnt;
`endif

  logic [7:0]  mem [0:16383];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren), .cpu_wrdata(cpu_wrdata),
    .cpu_ack(cpu_ack), .cpu_rddata(cpu_rddata), .cpu_rdvalid(cpu_rdvalid),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wren(dma_wren), .dma_wrdata(dma_wrdata),
    .dma_ack(dma_ack), .dma_rddata(dma_rddata), .dma_rdvalid(dma_rdvalid),
    .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
    .vram_rddata(vram_rddata)
`ifdef VRAM_ARB_STATS_EN
    , .stats_clr(stats_clr), .dma_stall_cnt(dma_stall_cnt)
`endif
  );

  always @(posedge clk) begin
    if (vram_wren) mem[vram_addr] <= vram_wrdata;
    vram_rddata <= mem[vram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, cpu_ack, cpu_rddata, cpu_rdvalid, dma_ack, dma_rddata, dma_rdvalid,
            vram_addr, vram_wrdata, vram_wren};
  endfunction

  // who: 0 = CPU, 1 = DMA. Request in cycle 0, ack in 1, data in 3.
  task automatic rd(input bit who, input logic [13:0] addr, input logic [7:0] exp, input string tag);
    if (!who) begin cpu_req = 1'b1; cpu_addr = addr; cpu_wren = 1'b0; end
    else      begin dma_req = 1'b1; dma_addr = addr; dma_wren = 1'b0; end
    step();
    check({tag, "_ack"}, who ? dma_ack : cpu_ack, 1);
    check({tag, "_addr"}, vram_addr, addr);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    step();
    check({tag, "_rv_early"}, who ? dma_rdvalid : cpu_rdvalid, 0);
    step();
    check({tag, "_rv"}, who ? dma_rdvalid : cpu_rdvalid, 1);
    check({tag, "_other_rv"}, who ? cpu_rdvalid : dma_rdvalid, 0);
    check({tag, "_data"}, who ? dma_rddata : cpu_rddata, exp);
    step();
    check({tag, "_rv_drop"}, who ? dma_rdvalid : cpu_rdvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int first_dma, n_dma, n_cpu, n_both, gap, max_gap, rv_seen;
    for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
    mem[14'h1234] = 8'hA5;
    mem[14'h0100] = 8'h01;
    mem[14'h0200] = 8'h02;
    reset_n = 1'b0;
    cpu_req = 0; cpu_addr = '0; cpu_wren = 0; cpu_wrdata = '0;
    dma_req = 0; dma_addr = '0; dma_wren = 0; dma_wrdata = '0;
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) step();
    check("rst_outs", all_outs(), 64'd0);
    #4 reset_n = 1'b1;
    step();
    check("post_rst_outs", all_outs(), 64'd0);

    // CPU-only read, then the port must hold its address while idle
    rd(1'b0, 14'h1234, 8'hA5, "cpu_rd");
    check("idle_addr_hold", vram_addr, 14'h1234);
    check("idle_wren", vram_wren, 0);
    check("dma_quiet", {dma_ack, dma_rdvalid, dma_rddata}, 0);

    // Simultaneous writes: CPU first, DMA next cycle
    cpu_req = 1; cpu_addr = 14'h0010; cpu_wren = 1; cpu_wrdata = 8'h11;
    dma_req = 1; dma_addr = 14'h0020; dma_wren = 1; dma_wrdata = 8'h22;
    step();
    check("sim_c1_acks", {cpu_ack, dma_ack}, 2'b10);
    check("sim_c1_port", {vram_addr, vram_wrdata, vram_wren}, {14'h0010, 8'h11, 1'b1});
    cpu_req = 0;
    step();
    check("sim_c2_acks", {cpu_ack, dma_ack}, 2'b01);
    check("sim_c2_port", {vram_addr, vram_wrdata, vram_wren}, {14'h0020, 8'h22, 1'b1});
    dma_req = 0;
    step();
    check("sim_c3_idle", {cpu_ack, dma_ack, vram_wren}, 0);
    step();
    check("wr_no_rv", {cpu_rdvalid, dma_rdvalid}, 0);
    rd(1'b0, 14'h0010, 8'h11, "rb_cpu");
    rd(1'b1, 14'h0020, 8'h22, "rb_dma");
    check("cpu_rddata_hold", cpu_rddata, 8'h11);

    // Pipelined reads in alternating grants
    cpu_req = 1; cpu_addr = 14'h0100; cpu_wren = 0;
    dma_req = 1; dma_addr = 14'h0200; dma_wren = 0;
    step();
    check("pipe_c1_cpu_ack", cpu_ack, 1);
    cpu_req = 0;
    step();
    check("pipe_c2_dma_ack", dma_ack, 1);
    dma_req = 0;
    step();
    check("pipe_c3_rv", {cpu_rdvalid, dma_rdvalid}, 2'b10);
    check("pipe_c3_cpu_data", cpu_rddata, 8'h01);
    step();
    check("pipe_c4_rv", {cpu_rdvalid, dma_rdvalid}, 2'b01);
    check("pipe_c4_dma_data", dma_rddata, 8'h02);
    check("pipe_c4_cpu_hold", cpu_rddata, 8'h01);
    step();

    // Both hammering the port: strict alternation, CPU on odd, DMA on even
    cpu_req = 1; cpu_addr = 14'h3000; cpu_wren = 1; cpu_wrdata = 8'hAA;
    dma_req = 1; dma_addr = 14'h3001; dma_wren = 1; dma_wrdata = 8'hBB;
    first_dma = 0; n_dma = 0; n_cpu = 0; n_both = 0; gap = 0; max_gap = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (dma_ack) begin
        n_dma++;
        if (first_dma == 0) first_dma = i;
        gap = 0;
      end else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
      if (cpu_ack) n_cpu++;
      if (cpu_ack && dma_ack) n_both++;
    end
    cpu_req = 0; dma_req = 0;
    check("starve_first_dma", first_dma, 2);
    check("starve_dma_acks", n_dma, 6);
    check("starve_cpu_acks", n_cpu, 6);
    check("starve_both_acks", n_both, 0);
    check("starve_max_gap", max_gap, 1);
    step();
    check("starve_drain", {cpu_ack, dma_ack}, 0);

    // Reset while a CPU read is in flight
    cpu_req = 1; cpu_addr = 14'h1234; cpu_wren = 0;
    step();
    check("mid_rst_ack", cpu_ack, 1);
    cpu_req = 0;
    #1 reset_n = 1'b0;
    #1 check("mid_rst_async", all_outs(), 64'd0);
    rv_seen = 0;
    repeat (2) begin
      step();
      if (cpu_rdvalid) rv_seen++;
    end
    #4 reset_n = 1'b1;
    step();
    check("mid_rst_release_outs", all_outs(), 64'd0);
    repeat (3) begin
      step();
      if (cpu_rdvalid) rv_seen++;
    end
    check("mid_rst_no_rv", rv_seen, 0);
    rd(1'b0, 14'h0100, 8'h01, "post_rst_rd");

`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1;
    step();
    stats_clr = 0;
    check("stats_clr0", dma_stall_cnt, 16'd0);
    for (int r = 0; r < 10; r++) begin
      cpu_req = 1; cpu_addr = 14'h2000; cpu_wren = 1; cpu_wrdata = 8'h5A;
      dma_req = 1; dma_addr = 14'h2001; dma_wren = 1; dma_wrdata = 8'hA5;
      step();
      cpu_req = 0;
      step();
      dma_req = 0;
      step();
    end
    check("stats_cnt", dma_stall_cnt, 16'd10);
    stats_clr = 1;
    step();
    stats_clr = 0;
    check("stats_clr1", dma_stall_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
